// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter and its dump scanner.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} arb_state_t;
endpackage

// File: rtl/dump_scanner.sv
// Dump scanner: walks every dmem word when granted and captures {addr,data} for the debug port.
module dump_scanner
  import dmem_arb_pkg::*;
#(
  parameter int N  = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_edge,
  input  logic          grant,
  input  logic [N-1:0]  mem_readData,
  output logic [AW-1:0] scan_addr,
  output logic          scan_active,
  output logic          dbg_busy,
  output logic          dbg_valid,
  output logic [AW-1:0] dbg_addr,
  output logic [N-1:0]  dbg_data,
  output logic          dbg_done
);

  localparam logic [AW-1:0] LAST = '1;

  arb_state_t    state_q, state_d;
  logic [AW-1:0] cnt_q;
  logic          capture;
  logic          vld_p1;
  logic          done_p1;
  logic [AW-1:0] addr_p1;
  logic [N-1:0]  data_p1;

  assign scan_active = (state_q == SCAN);
  assign capture     = scan_active & grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_edge) state_d = SCAN;
      SCAN:    if (capture && cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // capture stage: word read combinationally this cycle is registered at the edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= capture;
      done_p1 <= (state_q == DONE);
      if (state_q == IDLE && start_edge) begin
        cnt_q <= '0;
      end else if (capture) begin
        cnt_q   <= cnt_q + 1'b1;
        addr_p1 <= cnt_q;
        data_p1 <= mem_readData;
      end
    end
  end

  assign scan_addr = cnt_q;
  assign dbg_busy  = (state_q != IDLE);
  assign dbg_valid = vld_p1;
  assign dbg_addr  = addr_p1;
  assign dbg_data  = data_p1;
  assign dbg_done  = done_p1;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares dmem between the MEM stage and the debug dump scanner; CPU wins unless FREEZE holds it off.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N      = 64,
  parameter int AW     = 6,
  parameter int FREEZE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_readEnable,
  input  logic          cpu_writeEnable,
  input  logic [N-1:0]  cpu_addr,
  input  logic [N-1:0]  cpu_writeData,
  output logic [N-1:0]  cpu_readData,
  output logic          cpu_stall,
  input  logic          dbg_start,
  output logic          dbg_busy,
  output logic          dbg_valid,
  output logic [AW-1:0] dbg_addr,
  output logic [N-1:0]  dbg_data,
  output logic          dbg_done,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_address,
  output logic [N-1:0]  mem_writeData,
  input  logic [N-1:0]  mem_readData
);

  localparam bit FRZ = (FREEZE != 0);

  logic          start_q;
  logic          start_edge;
  logic          cpu_req;
  logic          grant;
  logic          scan_active;
  logic [AW-1:0] scan_addr;
  logic [AW-1:0] cpu_word;
  logic          unused_addr_bits;

  // Resetting high means a level already held through reset never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) start_q <= 1'b1;
    else       start_q <= dbg_start;
  end

  assign start_edge       = dbg_start & ~start_q;
  assign cpu_req          = cpu_readEnable | cpu_writeEnable;
  assign cpu_word         = cpu_addr[AW+2:3];
  assign unused_addr_bits = ^{cpu_addr[N-1:AW+3], cpu_addr[2:0]};
  assign grant            = scan_active & (FRZ | ~cpu_req);
  assign cpu_stall        = FRZ & scan_active;
  assign cpu_readData     = mem_readData;
  assign mem_writeData    = cpu_writeData;

  always_comb begin
    mem_read    = cpu_readEnable;
    mem_write   = cpu_writeEnable;
    mem_address = cpu_word;
    if (grant) begin
      mem_read    = 1'b1;
      mem_write   = 1'b0;
      mem_address = scan_addr;
    end
  end

  dump_scanner #(.N(N), .AW(AW)) u_scanner (
    .clk          (clk),
    .reset        (reset),
    .start_edge   (start_edge),
    .grant        (grant),
    .mem_readData (mem_readData),
    .scan_addr    (scan_addr),
    .scan_active  (scan_active),
    .dbg_busy     (dbg_busy),
    .dbg_valid    (dbg_valid),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data),
    .dbg_done     (dbg_done)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: FREEZE=0 and FREEZE=1 instances share stimulus, each with its own dmem and model.
module tb_dmem_arbiter;
  localparam int N     = 64;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          cpu_re = 1'b0;
  logic          cpu_we = 1'b0;
  logic [N-1:0]  cpu_addr = '0;
  logic [N-1:0]  cpu_wdata = '0;
  logic          dbg_start = 1'b0;
  logic          preload = 1'b0;

  logic [N-1:0]  cpu_rdata [2];
  logic          cpu_stall [2];
  logic          dbg_busy  [2];
  logic          dbg_valid [2];
  logic [AW-1:0] dbg_addr  [2];
  logic [N-1:0]  dbg_data  [2];
  logic          dbg_done  [2];
  logic          mem_read  [2];
  logic          mem_write [2];
  logic [AW-1:0] mem_addr  [2];
  logic [N-1:0]  mem_wdata [2];
  logic [N-1:0]  mem_rdata [2];
  logic [N-1:0]  dmem [2][DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(.N(N), .AW(AW), .FREEZE(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .cpu_readEnable(cpu_re), .cpu_writeEnable(cpu_we), .cpu_addr(cpu_addr),
    .cpu_writeData(cpu_wdata), .cpu_readData(cpu_rdata[0]), .cpu_stall(cpu_stall[0]),
    .dbg_start(dbg_start), .dbg_busy(dbg_busy[0]), .dbg_valid(dbg_valid[0]),
    .dbg_addr(dbg_addr[0]), .dbg_data(dbg_data[0]), .dbg_done(dbg_done[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_address(mem_addr[0]),
    .mem_writeData(mem_wdata[0]), .mem_readData(mem_rdata[0])
  );

  dmem_arbiter #(.N(N), .AW(AW), .FREEZE(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .cpu_readEnable(cpu_re), .cpu_writeEnable(cpu_we), .cpu_addr(cpu_addr),
    .cpu_writeData(cpu_wdata), .cpu_readData(cpu_rdata[1]), .cpu_stall(cpu_stall[1]),
    .dbg_start(dbg_start), .dbg_busy(dbg_busy[1]), .dbg_valid(dbg_valid[1]),
    .dbg_addr(dbg_addr[1]), .dbg_data(dbg_data[1]), .dbg_done(dbg_done[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_address(mem_addr[1]),
    .mem_writeData(mem_wdata[1]), .mem_readData(mem_rdata[1])
  );

  // dmem behaviour: combinational read, write on the clock edge
  assign mem_rdata[0] = dmem[0][mem_addr[0]];
  assign mem_rdata[1] = dmem[1][mem_addr[1]];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (preload) begin
        for (int i = 0; i < DEPTH; i++) dmem[k][i] <= N'(3 * i);
      end else if (mem_write[k]) begin
        dmem[k][mem_addr[k]] <= mem_wdata[k];
      end
    end
  end

  // Reference model: phase 0 idle, 1 scanning, 2 finishing; idx = next word to dump.
  int            m_phase [2];
  int            m_idx   [2];
  bit            m_prev  [2];
  bit            e_valid [2];
  bit            e_done  [2];
  logic [AW-1:0] e_addr  [2];
  logic [N-1:0]  e_data  [2];
  logic [N-1:0]  ref_mem [2][DEPTH];

  function automatic bit scan_owns(input int k);
    return (m_phase[k] == 1) && (k == 1 || !(cpu_re || cpu_we));
  endfunction

  always @(posedge clk or posedge reset) begin
    int ph;
    int ix;
    bit own;
    bit rise;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_phase[k] <= 0;
        m_idx[k]   <= 0;
        m_prev[k]  <= 1'b1;
        e_valid[k] <= 1'b0;
        e_done[k]  <= 1'b0;
        e_addr[k]  <= '0;
        e_data[k]  <= '0;
      end else begin
        ph   = m_phase[k];
        ix   = m_idx[k];
        own  = scan_owns(k);
        rise = dbg_start && !m_prev[k];
        m_prev[k]  <= dbg_start;
        e_valid[k] <= 1'b0;
        e_done[k]  <= 1'b0;
        if (preload) begin
          for (int i = 0; i < DEPTH; i++) ref_mem[k][i] <= N'(3 * i);
        end else if (!own && cpu_we) begin
          ref_mem[k][cpu_addr[8:3]] <= cpu_wdata;
        end
        if (ph == 0) begin
          if (rise) begin
            ph = 1;
            ix = 0;
          end
        end else if (ph == 1) begin
          if (own) begin
            e_valid[k] <= 1'b1;
            e_addr[k]  <= ix[AW-1:0];
            e_data[k]  <= ref_mem[k][ix];
            if (ix == DEPTH - 1) ph = 2;
            ix = (ix + 1) % DEPTH;
          end
        end else begin
          e_done[k] <= 1'b1;
          ph = 0;
        end
        m_phase[k] <= ph;
        m_idx[k]   <= ix;
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[dut%0d]: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit            own;
    logic [AW-1:0] ea;
    for (int k = 0; k < 2; k++) begin
      own = scan_owns(k);
      ea  = own ? m_idx[k][AW-1:0] : cpu_addr[8:3];
      chk("mem_read",    k, N'(mem_read[k]),  N'(own ? 1'b1 : cpu_re));
      chk("mem_write",   k, N'(mem_write[k]), N'(own ? 1'b0 : cpu_we));
      chk("mem_address", k, N'(mem_addr[k]),  N'(ea));
      if (!own) chk("mem_writeData", k, mem_wdata[k], cpu_wdata);
      if (!reset && !preload) chk("cpu_readData", k, cpu_rdata[k], ref_mem[k][ea]);
      chk("cpu_stall", k, N'(cpu_stall[k]), N'(k == 1 && m_phase[k] == 1));
      chk("dbg_busy",  k, N'(dbg_busy[k]),  N'(m_phase[k] != 0));
      chk("dbg_valid", k, N'(dbg_valid[k]), N'(e_valid[k]));
      chk("dbg_done",  k, N'(dbg_done[k]),  N'(e_done[k]));
      chk("dbg_addr",  k, N'(dbg_addr[k]),  N'(e_addr[k]));
      chk("dbg_data",  k, dbg_data[k],      e_data[k]);
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 dbg_start = 1'b1;
    @(posedge clk); #1 dbg_start = 1'b0;
  endtask

  // Observes one scan on both instances; optional CPU read burst or CPU write injected mid-scan.
  task automatic watch(input string tag, input int stall_at, input int write_at, input bit pattern,
                       output int nv0, output int nv1, output int lat0, output int lat1);
    int  first [2];
    bit  seen  [2];
    int  nv    [2];
    int  lat   [2];
    int  pbad;
    int  busy_bad;
    int  stall_left;
    bit  stalled;
    bit  wrote;
    pbad = 0; busy_bad = 0; stall_left = 0; stalled = 0; wrote = 0;
    for (int k = 0; k < 2; k++) begin first[k] = -1; seen[k] = 0; nv[k] = 0; lat[k] = -1; end
    for (int t = 0; t < 400 && !(seen[0] && seen[1]); t++) begin
      @(posedge clk); #1;
      cpu_we = 1'b0;
      if (stall_at >= 0 && !stalled && m_phase[0] == 1 && m_idx[0] == stall_at) begin
        stall_left = 3;
        stalled = 1;
      end
      cpu_re   = (stall_left > 0);
      cpu_addr = 64'h140;
      if (write_at >= 0 && !wrote && m_phase[1] == 1 && m_idx[1] == write_at) begin
        cpu_we    = 1'b1;
        cpu_addr  = 64'h08;
        cpu_wdata = 64'hDEAD;
        wrote     = 1;
      end
      @(negedge clk);
      if (stall_left > 0) begin
        chk({tag, "_cpu_read_word40"}, 0, cpu_rdata[0], 64'd120);
        chk({tag, "_no_capture_in_cpu_cycle"}, 0, N'(mem_address_is_cpu(0)), N'(1));
        stall_left--;
      end
      if (cpu_we) begin
        chk({tag, "_frozen_stall"}, 1, N'(cpu_stall[1]), N'(1));
        chk({tag, "_frozen_no_write"}, 1, N'(mem_write[1]), N'(0));
      end
      for (int k = 0; k < 2; k++) begin
        if (dbg_valid[k]) begin
          nv[k]++;
          if (first[k] < 0) first[k] = t;
          if (pattern && dbg_data[k] != N'(3 * int'(dbg_addr[k]))) pbad++;
        end
        if (dbg_done[k] && !seen[k]) begin
          seen[k] = 1;
          lat[k] = t - first[k];
          if (dbg_busy[k]) busy_bad++;
        end
      end
    end
    cpu_re = 1'b0;
    cpu_we = 1'b0;
    for (int k = 0; k < 2; k++) chk({tag, "_done_seen"}, k, N'(seen[k]), N'(1));
    if (pattern) chk({tag, "_data_is_3x_addr"}, 0, N'(pbad), N'(0));
    chk({tag, "_busy_low_with_done"}, 0, N'(busy_bad), N'(0));
    nv0 = nv[0]; nv1 = nv[1]; lat0 = lat[0]; lat1 = lat[1];
  endtask

  function automatic bit mem_address_is_cpu(input int k);
    return mem_addr[k] == cpu_addr[8:3] && !dbg_valid_next_expected(k);
  endfunction

  function automatic bit dbg_valid_next_expected(input int k);
    return scan_owns(k);
  endfunction

  initial begin
    int nv0, nv1, lat0, lat1, ndone, nbusy, guard;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_dbg_valid", k, N'(dbg_valid[k]), N'(0));
      chk("rst_dbg_busy",  k, N'(dbg_busy[k]),  N'(0));
      chk("rst_dbg_data",  k, dbg_data[k],      N'(0));
    end

    // CPU write passthrough in idle
    @(posedge clk); #1 cpu_we = 1'b1; cpu_addr = 64'h10; cpu_wdata = 64'd5;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("idle_wr_mem_write", k, N'(mem_write[k]), N'(1));
      chk("idle_wr_address",   k, N'(mem_addr[k]),  N'(2));
      chk("idle_wr_data",      k, mem_wdata[k],     N'(5));
      chk("idle_wr_no_valid",  k, N'(dbg_valid[k]), N'(0));
    end
    @(posedge clk); #1 cpu_we = 1'b0;

    @(posedge clk); #1 preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;

    // clean scan
    pulse_start();
    watch("clean", -1, -1, 1'b1, nv0, nv1, lat0, lat1);
    chk("clean_count", 0, N'(nv0), N'(64));
    chk("clean_count", 1, N'(nv1), N'(64));
    chk("clean_latency", 0, N'(lat0), N'(64));
    chk("clean_latency", 1, N'(lat1), N'(64));

    // CPU reads during scan at cnt=5
    pulse_start();
    watch("cpuwin", 5, -1, 1'b1, nv0, nv1, lat0, lat1);
    chk("cpuwin_count", 0, N'(nv0), N'(64));
    chk("cpuwin_latency", 0, N'(lat0), N'(67));
    chk("cpuwin_latency", 1, N'(lat1), N'(64));

    // CPU write to word 1 during scan
    pulse_start();
    watch("frz", -1, 20, 1'b0, nv0, nv1, lat0, lat1);
    @(negedge clk);
    chk("frz_mem1_unchanged", 1, dmem[1][1], 64'd3);
    chk("nofrz_mem1_written", 0, dmem[0][1], 64'hDEAD);

    // async reset mid-scan
    pulse_start();
    repeat (10) @(posedge clk);
    @(negedge clk); #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("async_rst_valid", k, N'(dbg_valid[k]), N'(0));
      chk("async_rst_addr",  k, N'(dbg_addr[k]),  N'(0));
      chk("async_rst_busy",  k, N'(dbg_busy[k]),  N'(0));
    end
    cpu_re = 1'b1; cpu_addr = 64'h18;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_rd_mem_read", k, N'(mem_read[k]), N'(1));
      chk("rst_rd_address",  k, N'(mem_addr[k]), N'(3));
    end
    @(posedge clk); #3 reset = 1'b0; cpu_re = 1'b0;

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      cpu_re    = ($urandom_range(0, 3) == 0);
      cpu_we    = ($urandom_range(0, 6) == 0);
      cpu_addr  = {$urandom, $urandom};
      cpu_wdata = {$urandom, $urandom};
      if ($urandom_range(0, 39) == 0) dbg_start = ~dbg_start;
    end
    @(posedge clk); #1 cpu_re = 1'b0; cpu_we = 1'b0; dbg_start = 1'b0;
    guard = 0;
    while ((m_phase[0] != 0 || m_phase[1] != 0) && guard < 300) begin
      @(posedge clk); #1 guard++;
    end
    chk("random_drain_idle", 0, N'(guard < 300), N'(1));

    // reset at cnt=30 with dbg_start held high
    @(posedge clk); #1 dbg_start = 1'b1;
    guard = 0;
    while (!(m_phase[0] == 1 && m_idx[0] == 30) && guard < 300) begin
      @(posedge clk); #1 guard++;
    end
    chk("reach_cnt30", 0, N'(guard < 300), N'(1));
    @(negedge clk); #2 reset = 1'b1;
    @(posedge clk); #3 reset = 1'b0;
    ndone = 0; nbusy = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (dbg_done[k]) ndone++;
        if (dbg_busy[k]) nbusy++;
      end
    end
    chk("held_start_no_done", 0, N'(ndone), N'(0));
    chk("held_start_no_busy", 0, N'(nbusy), N'(0));
    @(posedge clk); #1 dbg_start = 1'b0;
    @(posedge clk); #1 dbg_start = 1'b1;
    watch("restart", -1, -1, 1'b0, nv0, nv1, lat0, lat1);
    chk("restart_count", 0, N'(nv0), N'(64));
    chk("restart_count", 1, N'(nv1), N'(64));
    chk("restart_latency", 0, N'(lat0), N'(64));

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
